recovery_event_tracker: RTL and testbench

//  Multi-channel, registered successor to the single-channel combinational recovery event mux.
//  Per channel it qualifies primary/secondary pin edges per input mode and detects differential violations.
//  It also decodes quadrature into a signed position/direction, and runs a per-channel tracking FSM with pause timeout and fault latching.

---
 rtl/recovery_event_tracker_pkg.sv | 74 +++++++
 rtl/recovery_event_tracker_channel.sv | 196 +++++++++++++++++++
 rtl/recovery_event_tracker.sv | 47 ++++
 tb/tb_recovery_event_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/recovery_event_tracker_pkg.sv
// Shared types for the multi-channel recovery event tracker: clock domain, pin/event
// bundles, input modes, tracking states and quadrature phase helper.
package clks_alot_p;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_POS_W      = 16;
    localparam int DEF_TIMEOUT_W  = 12;
    localparam int DEF_VIOL_LIMIT = 3;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

    typedef enum logic [2:0] {
        SINGLE_CONTINUOUS = 3'd0,
        SINGLE_PAUSABLE   = 3'd1,
        DIF_CONTINUOUS    = 3'd2,
        DIF_PAUSABLE      = 3'd3,
        QUAD_CONTINUOUS   = 3'd4,
        QUAD_PAUSABLE     = 3'd5
    } input_mode_e;

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        ACQUIRE  = 3'd1,
        TRACKING = 3'd2,
        PAUSED   = 3'd3,
        FAULT    = 3'd4
    } track_state_e;

    typedef struct packed {
        logic prim_rise;
        logic prim_fall;
        logic sec_rise;
        logic sec_fall;
    } driver_events_s;

    typedef struct packed {
        logic primary;
        logic secondary;
    } recovery_pins_s;

    typedef struct packed {
        logic rising_edge;
        logic falling_edge;
        logic any_edge;
        logic rise_violation;
        logic fall_violation;
    } recovered_events_s;

    function automatic logic mode_is_quad(input input_mode_e m);
        return (m == QUAD_CONTINUOUS) || (m == QUAD_PAUSABLE);
    endfunction

    function automatic logic mode_is_dif(input input_mode_e m);
        return (m == DIF_CONTINUOUS) || (m == DIF_PAUSABLE);
    endfunction

    function automatic logic mode_is_pausable(input input_mode_e m);
        return (m == SINGLE_PAUSABLE) || (m == DIF_PAUSABLE) || (m == QUAD_PAUSABLE);
    endfunction

    // Position of a {P,S} level pair along the forward cycle 00->10->11->01
    function automatic logic [1:0] quad_phase(input logic [1:0] lvl);
        case (lvl)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/recovery_event_tracker_channel.sv
// Single recovery channel: edge qualification, quadrature decode, violation/idle
// counters and the tracking FSM with pause timeout and fault latching.
module recovery_channel_tracker
    import clks_alot_p::*;
#(
    parameter int POS_W      = DEF_POS_W,
    parameter int TIMEOUT_W  = DEF_TIMEOUT_W,
    parameter int VIOL_LIMIT = DEF_VIOL_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  input_mode_e          mode,
    input  driver_events_s       drv_events,
    input  recovery_pins_s       pins,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic                 fault_clr,
    output recovered_events_s    events,
    output logic [POS_W-1:0]     quad_pos,
    output logic                 quad_dir,
    output track_state_e         state,
    output logic                 fault
);

    localparam int                   VC_W     = $clog2(VIOL_LIMIT + 1);
    localparam logic [VC_W-1:0]      VIOL_MAX = VC_W'(VIOL_LIMIT);
    localparam logic [TIMEOUT_W-1:0] IDLE_MAX = '1;

    track_state_e         state_q, state_next;
    input_mode_e          mode_q;
    logic [VC_W-1:0]      viol_q, viol_next, viol_upd;
    logic [TIMEOUT_W-1:0] idle_q, idle_next, idle_inc;
    logic [POS_W-1:0]     pos_q, pos_next;
    logic                 dir_q, dir_next;
    logic [1:0]           prev_lvl, cur_lvl, step;
    logic                 prev_valid;
    recovered_events_s    qual, events_q;
    logic                 fault_q;
    logic                 is_quad, is_dif, active, mode_changed, quad_ok;
    logic                 quad_fwd, quad_rev, quad_viol;
    logic                 violation, any_valid, viol_hit, timed_out;

    assign is_quad      = mode_is_quad(mode);
    assign is_dif       = mode_is_dif(mode);
    assign active       = (state_q == ACQUIRE) || (state_q == TRACKING) || (state_q == PAUSED);
    assign mode_changed = (state_q != DISABLED) && (mode != mode_q);

    always_comb begin
        qual = '0;
        if (is_quad) begin
            qual.any_edge = |drv_events;
        end else if (is_dif) begin
            qual.rising_edge    = drv_events.prim_rise & drv_events.sec_fall;
            qual.falling_edge   = drv_events.prim_fall & drv_events.sec_rise;
            qual.any_edge       = qual.rising_edge | qual.falling_edge;
            qual.rise_violation = drv_events.prim_rise & ~drv_events.sec_fall;
            qual.fall_violation = drv_events.prim_fall & ~drv_events.sec_rise;
        end else begin
            qual.rising_edge  = drv_events.prim_rise;
            qual.falling_edge = drv_events.prim_fall;
            qual.any_edge     = drv_events.prim_rise | drv_events.prim_fall;
        end
    end

    // prev_valid stays low for the first cycle after reset so that cycle never counts as a step
    assign cur_lvl   = {pins.primary, pins.secondary};
    assign step      = quad_phase(cur_lvl) - quad_phase(prev_lvl);
    assign quad_ok   = is_quad & prev_valid;
    assign quad_fwd  = quad_ok & (step == 2'd1);
    assign quad_rev  = quad_ok & (step == 2'd3);
    assign quad_viol = quad_ok & (step == 2'd2);

    assign violation = qual.rise_violation | qual.fall_violation | quad_viol;
    assign any_valid = qual.any_edge & ~quad_viol;
    assign idle_inc  = (idle_q == IDLE_MAX) ? idle_q : idle_q + TIMEOUT_W'(1);

    always_comb begin
        if (violation) begin
            viol_upd = (viol_q == VIOL_MAX) ? viol_q : viol_q + VC_W'(1);
        end else if (any_valid) begin
            viol_upd = '0;
        end else begin
            viol_upd = viol_q;
        end
    end

    assign viol_hit  = violation && (viol_upd == VIOL_MAX);
    assign timed_out = (timeout != '0) && !any_valid && (idle_inc == timeout);

    // Priority: disable, then mode change, then violation fault, then timeout
    always_comb begin
        state_next = state_q;
        viol_next  = viol_q;
        idle_next  = idle_q;
        pos_next   = pos_q;
        dir_next   = dir_q;

        if (!en) begin
            state_next = DISABLED;
            viol_next  = '0;
            idle_next  = '0;
            pos_next   = '0;
        end else if (state_q == DISABLED || mode_changed) begin
            state_next = ACQUIRE;
            viol_next  = '0;
            idle_next  = '0;
            pos_next   = '0;
        end else begin
            if (active) begin
                viol_next = viol_upd;
                if (quad_fwd) begin
                    pos_next = pos_q + POS_W'(1);
                    dir_next = 1'b1;
                end else if (quad_rev) begin
                    pos_next = pos_q - POS_W'(1);
                    dir_next = 1'b0;
                end
            end

            case (state_q)
                ACQUIRE: begin
                    if (viol_hit) begin
                        state_next = FAULT;
                    end else if (any_valid) begin
                        state_next = TRACKING;
                        idle_next  = '0;
                    end
                end
                TRACKING: begin
                    if (viol_hit) begin
                        state_next = FAULT;
                    end else if (any_valid) begin
                        idle_next = '0;
                    end else begin
                        idle_next = idle_inc;
                        if (timed_out) begin
                            state_next = mode_is_pausable(mode) ? PAUSED : FAULT;
                        end
                    end
                end
                PAUSED: begin
                    if (viol_hit) begin
                        state_next = FAULT;
                    end else if (any_valid) begin
                        state_next = TRACKING;
                        idle_next  = '0;
                    end
                end
                FAULT: begin
                    // The count stays saturated here, so a violation alongside the clear re-latches
                    if (fault_clr && !viol_hit) begin
                        state_next = ACQUIRE;
                        viol_next  = '0;
                        idle_next  = '0;
                    end
                end
                default: begin
                    state_next = DISABLED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISABLED;
            mode_q     <= SINGLE_CONTINUOUS;
            viol_q     <= '0;
            idle_q     <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b1;
            prev_lvl   <= '0;
            prev_valid <= 1'b0;
            events_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_next;
            mode_q     <= mode;
            viol_q     <= viol_next;
            idle_q     <= idle_next;
            pos_q      <= pos_next;
            dir_q      <= dir_next;
            prev_lvl   <= cur_lvl;
            prev_valid <= 1'b1;
            events_q   <= active ? qual : '0;
            fault_q    <= (state_next == FAULT);
        end
    end

    assign events   = events_q;
    assign quad_pos = pos_q;
    assign quad_dir = dir_q;
    assign state    = state_q;
    assign fault    = fault_q;

endmodule

// File: rtl/recovery_event_tracker.sv
// Multi-channel recovery event tracker: one independent recovery_channel_tracker per
// channel between the pin edge detectors and the clock recovery logic.
module recovery_event_tracker
    import clks_alot_p::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int POS_W      = DEF_POS_W,
    parameter int TIMEOUT_W  = DEF_TIMEOUT_W,
    parameter int VIOL_LIMIT = DEF_VIOL_LIMIT
) (
    input  clk_dom_s             sys_dom_i,
    input  logic [CHANNELS-1:0]  recovery_en_i,
    input  input_mode_e          recovery_mode_i    [CHANNELS],
    input  driver_events_s       driver_events_i    [CHANNELS],
    input  recovery_pins_s       io_clk_i           [CHANNELS],
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [CHANNELS-1:0]  fault_clr_i,
    output recovered_events_s    recovered_events_o [CHANNELS],
    output logic [POS_W-1:0]     quad_pos_o         [CHANNELS],
    output logic [CHANNELS-1:0]  quad_dir_o,
    output track_state_e         state_o            [CHANNELS],
    output logic [CHANNELS-1:0]  fault_o
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        recovery_channel_tracker #(
            .POS_W      (POS_W),
            .TIMEOUT_W  (TIMEOUT_W),
            .VIOL_LIMIT (VIOL_LIMIT)
        ) u_chan (
            .clk        (sys_dom_i.clk),
            .rst_n      (sys_dom_i.rst_n),
            .en         (recovery_en_i[ch]),
            .mode       (recovery_mode_i[ch]),
            .drv_events (driver_events_i[ch]),
            .pins       (io_clk_i[ch]),
            .timeout    (timeout_i),
            .fault_clr  (fault_clr_i[ch]),
            .events     (recovered_events_o[ch]),
            .quad_pos   (quad_pos_o[ch]),
            .quad_dir   (quad_dir_o[ch]),
            .state      (state_o[ch]),
            .fault      (fault_o[ch])
        );
    end

endmodule

// File: tb/tb_recovery_event_tracker.sv
// Directed self-checking bench for recovery_event_tracker: DIF qualification and faults,
// quadrature decode, pause timeout, channel isolation and async reset.
module tb_recovery_event_tracker;
    import clks_alot_p::*;

    localparam int CH = DEF_CHANNELS;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    clk_dom_s                 sys_dom;
    logic [CH-1:0]            en, fault_clr, quad_dir, fault;
    input_mode_e              mode [CH];
    driver_events_s           drv  [CH];
    recovery_pins_s           pins [CH];
    logic [DEF_TIMEOUT_W-1:0] timeout;
    recovered_events_s        rec  [CH];
    logic [DEF_POS_W-1:0]     pos  [CH];
    track_state_e             st   [CH];
    int                       vec_cnt = 0;
    int                       err_cnt = 0;

    assign sys_dom.clk   = clk;
    assign sys_dom.rst_n = rst_n;

    always #5 clk = ~clk;

    recovery_event_tracker dut (
        .sys_dom_i          (sys_dom),
        .recovery_en_i      (en),
        .recovery_mode_i    (mode),
        .driver_events_i    (drv),
        .io_clk_i           (pins),
        .timeout_i          (timeout),
        .fault_clr_i        (fault_clr),
        .recovered_events_o (rec),
        .quad_pos_o         (pos),
        .quad_dir_o         (quad_dir),
        .state_o            (st),
        .fault_o            (fault)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_events();
        for (int i = 0; i < CH; i++) drv[i] = '0;
    endtask

    // Move a channel's pins to a new {P,S} level and raise the matching edge pulses
    task automatic drive_quad(input int ch, input logic [1:0] lvl);
        logic [1:0] old;
        old = {pins[ch].primary, pins[ch].secondary};
        drv[ch]           = '0;
        drv[ch].prim_rise = ~old[1] & lvl[1];
        drv[ch].prim_fall = old[1] & ~lvl[1];
        drv[ch].sec_rise  = ~old[0] & lvl[0];
        drv[ch].sec_fall  = old[0] & ~lvl[0];
        pins[ch].primary   = lvl[1];
        pins[ch].secondary = lvl[0];
    endtask

    task automatic test_reset();
        en = '0; fault_clr = '0; timeout = '0;
        for (int i = 0; i < CH; i++) begin
            mode[i] = SINGLE_CONTINUOUS;
            drv[i]  = '0;
            pins[i] = '0;
        end
        rst_n = 1'b0;
        tick(2);
        for (int i = 0; i < CH; i++) begin
            vec_cnt++; if (st[i] !== DISABLED) begin err_cnt++; $display("[TB] FAIL reset_state ch%0d: got %0d want %0d", i, st[i], DISABLED); end
            vec_cnt++; if (pos[i] !== 16'h0000) begin err_cnt++; $display("[TB] FAIL reset_pos ch%0d: got %0h want 0", i, pos[i]); end
            vec_cnt++; if (rec[i] !== 5'b0) begin err_cnt++; $display("[TB] FAIL reset_events ch%0d: got %0b want 0", i, rec[i]); end
        end
        vec_cnt++; if (quad_dir !== 4'b1111) begin err_cnt++; $display("[TB] FAIL reset_dir: got %0b want 1111", quad_dir); end
        vec_cnt++; if (fault !== 4'b0000) begin err_cnt++; $display("[TB] FAIL reset_fault: got %0b want 0000", fault); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_dif();
        mode[0] = DIF_CONTINUOUS; en[0] = 1'b1;
        tick();
        vec_cnt++; if (st[0] !== ACQUIRE) begin err_cnt++; $display("[TB] FAIL dif_acquire: got %0d want %0d", st[0], ACQUIRE); end
        drv[0].prim_rise = 1'b1; drv[0].sec_fall = 1'b1;
        tick();
        vec_cnt++; if (rec[0].rising_edge !== 1'b1) begin err_cnt++; $display("[TB] FAIL dif_rise: got %0b want 1", rec[0].rising_edge); end
        vec_cnt++; if (rec[0].falling_edge !== 1'b0) begin err_cnt++; $display("[TB] FAIL dif_rise_nofall: got %0b want 0", rec[0].falling_edge); end
        vec_cnt++; if (st[0] !== TRACKING) begin err_cnt++; $display("[TB] FAIL dif_track: got %0d want %0d", st[0], TRACKING); end
        clear_events();
        tick();
        vec_cnt++; if (rec[0].rising_edge !== 1'b0) begin err_cnt++; $display("[TB] FAIL dif_rise_clear: got %0b want 0", rec[0].rising_edge); end
        drv[0].prim_rise = 1'b1;
        tick();
        vec_cnt++; if (rec[0].rise_violation !== 1'b1) begin err_cnt++; $display("[TB] FAIL dif_rise_viol: got %0b want 1", rec[0].rise_violation); end
        vec_cnt++; if (rec[0].rising_edge !== 1'b0) begin err_cnt++; $display("[TB] FAIL dif_viol_norise: got %0b want 0", rec[0].rising_edge); end
        tick();
        vec_cnt++; if (st[0] !== TRACKING || fault[0] !== 1'b0) begin err_cnt++; $display("[TB] FAIL dif_viol2: state %0d fault %0b want %0d 0", st[0], fault[0], TRACKING); end
        tick();
        vec_cnt++; if (st[0] !== FAULT) begin err_cnt++; $display("[TB] FAIL dif_viol3_state: got %0d want %0d", st[0], FAULT); end
        vec_cnt++; if (fault[0] !== 1'b1) begin err_cnt++; $display("[TB] FAIL dif_viol3_fault: got %0b want 1", fault[0]); end
        fault_clr[0] = 1'b1;
        tick();
        vec_cnt++; if (st[0] !== FAULT || fault[0] !== 1'b1) begin err_cnt++; $display("[TB] FAIL clr_with_viol: state %0d fault %0b want %0d 1", st[0], fault[0], FAULT); end
        vec_cnt++; if (rec[0] !== 5'b0) begin err_cnt++; $display("[TB] FAIL fault_gated_events: got %0b want 0", rec[0]); end
        clear_events();
        tick();
        fault_clr[0] = 1'b0;
        vec_cnt++; if (st[0] !== ACQUIRE || fault[0] !== 1'b0) begin err_cnt++; $display("[TB] FAIL clr_acquire: state %0d fault %0b want %0d 0", st[0], fault[0], ACQUIRE); end
        drv[0].prim_fall = 1'b1; drv[0].sec_rise = 1'b1;
        tick();
        vec_cnt++; if (rec[0].falling_edge !== 1'b1 || st[0] !== TRACKING) begin err_cnt++; $display("[TB] FAIL dif_fall: fall %0b state %0d want 1 %0d", rec[0].falling_edge, st[0], TRACKING); end
        clear_events();
        en[0] = 1'b0;
        tick();
        vec_cnt++; if (st[0] !== DISABLED) begin err_cnt++; $display("[TB] FAIL dif_disable: got %0d want %0d", st[0], DISABLED); end
    endtask

    task automatic test_quad();
        logic [1:0] fwd_seq [4];
        logic [1:0] rev_seq [4];
        fwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        mode[1] = QUAD_CONTINUOUS; en[1] = 1'b1;
        tick();
        vec_cnt++; if (st[1] !== ACQUIRE) begin err_cnt++; $display("[TB] FAIL quad_acquire: got %0d want %0d", st[1], ACQUIRE); end
        for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) begin drive_quad(1, fwd_seq[k]); tick(); end
        clear_events();
        vec_cnt++; if (pos[1] !== 16'd16) begin err_cnt++; $display("[TB] FAIL quad_fwd_pos: got %0h want 10", pos[1]); end
        vec_cnt++; if (quad_dir[1] !== 1'b1 || st[1] !== TRACKING) begin err_cnt++; $display("[TB] FAIL quad_fwd_dir: dir %0b state %0d want 1 %0d", quad_dir[1], st[1], TRACKING); end
        for (int r = 0; r < 4; r++) for (int k = 0; k < 4; k++) begin drive_quad(1, rev_seq[k]); tick(); end
        vec_cnt++; if (pos[1] !== 16'd0 || quad_dir[1] !== 1'b0) begin err_cnt++; $display("[TB] FAIL quad_rev: pos %0h dir %0b want 0 0", pos[1], quad_dir[1]); end
        drive_quad(1, 2'b01); tick();
        vec_cnt++; if (pos[1] !== 16'hFFFF) begin err_cnt++; $display("[TB] FAIL quad_underflow: got %0h want ffff", pos[1]); end
        drive_quad(1, 2'b10); tick();
        vec_cnt++; if (pos[1] !== 16'hFFFF || quad_dir[1] !== 1'b0) begin err_cnt++; $display("[TB] FAIL quad_jump_hold: pos %0h dir %0b want ffff 0", pos[1], quad_dir[1]); end
        drive_quad(1, 2'b11); tick();
        vec_cnt++; if (pos[1] !== 16'h0000 || quad_dir[1] !== 1'b1) begin err_cnt++; $display("[TB] FAIL quad_wrap_fwd: pos %0h dir %0b want 0 1", pos[1], quad_dir[1]); end
        drive_quad(1, 2'b01); tick();
        drive_quad(1, 2'b00); tick();
        clear_events();
        vec_cnt++; if (pos[1] !== 16'd2) begin err_cnt++; $display("[TB] FAIL quad_pos2: got %0h want 2", pos[1]); end
        en[1] = 1'b0;
        tick();
        vec_cnt++; if (st[1] !== DISABLED || pos[1] !== 16'd0) begin err_cnt++; $display("[TB] FAIL quad_disable: state %0d pos %0h want %0d 0", st[1], pos[1], DISABLED); end
        en[1] = 1'b1;
        tick();
        drive_quad(1, 2'b11); tick();
        drive_quad(1, 2'b00); tick();
        vec_cnt++; if (st[1] !== ACQUIRE || fault[1] !== 1'b0) begin err_cnt++; $display("[TB] FAIL quad_viol2: state %0d fault %0b want %0d 0", st[1], fault[1], ACQUIRE); end
        drive_quad(1, 2'b11); tick();
        clear_events();
        vec_cnt++; if (st[1] !== FAULT || fault[1] !== 1'b1 || pos[1] !== 16'd0) begin err_cnt++; $display("[TB] FAIL quad_viol3: state %0d fault %0b pos %0h want %0d 1 0", st[1], fault[1], pos[1], FAULT); end
        en[1] = 1'b0;
        tick();
        vec_cnt++; if (st[1] !== DISABLED || fault[1] !== 1'b0) begin err_cnt++; $display("[TB] FAIL quad_fault_disable: state %0d fault %0b want %0d 0", st[1], fault[1], DISABLED); end
    endtask

    task automatic test_pause();
        timeout = 12'd10;
        mode[3] = SINGLE_PAUSABLE; en[3] = 1'b1;
        tick();
        drv[3].prim_rise = 1'b1;
        tick();
        clear_events();
        vec_cnt++; if (st[3] !== TRACKING || rec[3].rising_edge !== 1'b1) begin err_cnt++; $display("[TB] FAIL pause_enter_track: state %0d rise %0b want %0d 1", st[3], rec[3].rising_edge, TRACKING); end
        tick(9);
        vec_cnt++; if (st[3] !== TRACKING) begin err_cnt++; $display("[TB] FAIL pause_idle9: got %0d want %0d", st[3], TRACKING); end
        tick();
        vec_cnt++; if (st[3] !== PAUSED) begin err_cnt++; $display("[TB] FAIL pause_idle10: got %0d want %0d", st[3], PAUSED); end
        drv[3].prim_fall = 1'b1;
        tick();
        clear_events();
        vec_cnt++; if (st[3] !== TRACKING || rec[3].falling_edge !== 1'b1) begin err_cnt++; $display("[TB] FAIL pause_resume: state %0d fall %0b want %0d 1", st[3], rec[3].falling_edge, TRACKING); end
        mode[3] = SINGLE_CONTINUOUS;
        tick();
        vec_cnt++; if (st[3] !== ACQUIRE) begin err_cnt++; $display("[TB] FAIL mode_change_acquire: got %0d want %0d", st[3], ACQUIRE); end
        drv[3].prim_rise = 1'b1;
        tick();
        clear_events();
        tick(9);
        vec_cnt++; if (st[3] !== TRACKING) begin err_cnt++; $display("[TB] FAIL cont_idle9: got %0d want %0d", st[3], TRACKING); end
        tick();
        vec_cnt++; if (st[3] !== FAULT || fault[3] !== 1'b1) begin err_cnt++; $display("[TB] FAIL cont_timeout_fault: state %0d fault %0b want %0d 1", st[3], fault[3], FAULT); end
        en[3] = 1'b0;
        timeout = '0;
        tick();
        vec_cnt++; if (st[3] !== DISABLED || fault[3] !== 1'b0) begin err_cnt++; $display("[TB] FAIL pause_disable: state %0d fault %0b want %0d 0", st[3], fault[3], DISABLED); end
    endtask

    task automatic test_isolation();
        logic [1:0] iso_seq [3];
        iso_seq = '{2'b01, 2'b00, 2'b10};
        mode[0] = SINGLE_CONTINUOUS; mode[1] = QUAD_CONTINUOUS; mode[2] = DIF_CONTINUOUS;
        en = 4'b0111;
        tick();
        for (int i = 0; i < 3; i++) begin
            vec_cnt++; if (st[i] !== ACQUIRE) begin err_cnt++; $display("[TB] FAIL iso_acquire ch%0d: got %0d want %0d", i, st[i], ACQUIRE); end
        end
        drv[0].prim_rise = 1'b1;
        drv[2].prim_rise = 1'b1;
        for (int k = 0; k < 3; k++) begin drive_quad(1, iso_seq[k]); tick(); end
        clear_events();
        vec_cnt++; if (fault !== 4'b0100) begin err_cnt++; $display("[TB] FAIL iso_fault_vec: got %0b want 0100", fault); end
        vec_cnt++; if (st[2] !== FAULT) begin err_cnt++; $display("[TB] FAIL iso_ch2_fault: got %0d want %0d", st[2], FAULT); end
        vec_cnt++; if (st[0] !== TRACKING || st[1] !== TRACKING) begin err_cnt++; $display("[TB] FAIL iso_others_track: ch0 %0d ch1 %0d want %0d", st[0], st[1], TRACKING); end
        vec_cnt++; if (pos[1] !== 16'd3 || quad_dir[1] !== 1'b1) begin err_cnt++; $display("[TB] FAIL iso_ch1_pos: pos %0h dir %0b want 3 1", pos[1], quad_dir[1]); end
        vec_cnt++; if (st[3] !== DISABLED) begin err_cnt++; $display("[TB] FAIL iso_ch3_idle: got %0d want %0d", st[3], DISABLED); end
        mode[1] = QUAD_PAUSABLE;
        tick();
        vec_cnt++; if (st[1] !== ACQUIRE || pos[1] !== 16'd0 || st[2] !== FAULT) begin err_cnt++; $display("[TB] FAIL iso_mode_change: ch1 %0d pos %0h ch2 %0d want %0d 0 %0d", st[1], pos[1], st[2], ACQUIRE, FAULT); end
    endtask

    task automatic test_async_reset();
        drv[0].prim_rise = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) begin
            vec_cnt++; if (st[i] !== DISABLED || pos[i] !== 16'd0 || rec[i] !== 5'b0) begin err_cnt++; $display("[TB] FAIL async_reset ch%0d: state %0d pos %0h ev %0b want %0d 0 0", i, st[i], pos[i], rec[i], DISABLED); end
        end
        vec_cnt++; if (fault !== 4'b0000 || quad_dir !== 4'b1111) begin err_cnt++; $display("[TB] FAIL async_reset_vec: fault %0b dir %0b want 0000 1111", fault, quad_dir); end
        clear_events();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_quad(1, 2'b11);
        tick();
        clear_events();
        vec_cnt++; if (st[1] !== ACQUIRE || pos[1] !== 16'd0) begin err_cnt++; $display("[TB] FAIL post_reset_first: state %0d pos %0h want %0d 0", st[1], pos[1], ACQUIRE); end
        drive_quad(1, 2'b01);
        tick();
        clear_events();
        vec_cnt++; if (st[1] !== TRACKING || pos[1] !== 16'd1) begin err_cnt++; $display("[TB] FAIL post_reset_step: state %0d pos %0h want %0d 1", st[1], pos[1], TRACKING); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_dif();
        test_quad();
        test_pause();
        test_isolation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
